// File: rtl/fir_seq16x6_pkg.sv
// Shared types and constants for the fir_seq16x6 FIR tap sequencer.
// Optional macro FIR_PIPE_EN adds a product register ahead of the accumulator.
package fir_seq_pkg;

    localparam int SRL_DEPTH = 16;
    localparam int SRL_W     = 6;
    localparam int TAP_AW    = 4;
    // One extra bit so the tap counter can reach TAPS in the pipelined build
    localparam int KW        = TAP_AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        MAC,
        DONE
    } state_t;

endpackage

// File: rtl/fir_seq16x6_if.sv
// Sample-in / result-out handshake bundle for fir_seq16x6.
// Unaffected by FIR_PIPE_EN.
interface fir_seq16x6_if #(
    parameter int ACCW = 22
);
    import fir_seq_pkg::*;

    logic signed [SRL_W-1:0] din;
    logic                    din_stb;
    logic signed [ACCW-1:0]  dout;
    logic                    dout_stb;
    logic                    busy;
    logic                    ovr;

    modport master (
        output din, din_stb,
        input  dout, dout_stb, busy, ovr
    );

    modport slave (
        input  din, din_stb,
        output dout, dout_stb, busy, ovr
    );

endinterface

// File: rtl/fir_seq16x6_mac.sv
// Signed tap multiplier and accumulator for fir_seq16x6.
// With FIR_PIPE_EN defined the product and its first/valid flags are registered once.
module fir_mac
    import fir_seq_pkg::*;
#(
    parameter int CW   = 12,
    parameter int ACCW = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   first,
    input  logic                   valid,
    input  logic [SRL_W-1:0]       srl_y,
    input  logic [CW-1:0]          coef,
    output logic signed [ACCW-1:0] acc
);

    localparam int PW = SRL_W + CW;

    logic signed [PW-1:0]   yExt;
    logic signed [PW-1:0]   cExt;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prodExt;
    logic signed [ACCW-1:0] stepProd;
    logic                   stepFirst;
    logic                   stepValid;

    // Both operands are widened to the full product width so the multiply is exact
    assign yExt    = PW'($signed(srl_y));
    assign cExt    = PW'($signed(coef));
    assign prod    = yExt * cExt;
    assign prodExt = ACCW'(prod);

`ifdef FIR_PIPE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stepProd  <= '0;
            stepFirst <= 1'b0;
            stepValid <= 1'b0;
        end else begin
            stepProd  <= prodExt;
            stepFirst <= first;
            stepValid <= valid;
        end
    end
`else
    assign stepProd  = prodExt;
    assign stepFirst = first;
    assign stepValid = valid;
`endif

    // The first tap of a sweep overwrites the accumulator instead of adding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (stepValid) begin
            acc <= stepFirst ? stepProd : acc + stepProd;
        end
    end

endmodule

// File: rtl/fir_seq16x6.sv
// FIR tap sequencer: shifts each sample into the external delay line, sweeps taps, emits one result.
// Define FIR_PIPE_EN to pipeline the multiplier (MAC phase one cycle longer).
module fir_seq16x6
    import fir_seq_pkg::*;
#(
    parameter int TAPS = 16,
    parameter int CW   = 12,
    parameter int ACCW = 22
) (
    input  logic              clk,
    input  logic              rst,
    fir_seq16x6_if.slave      smp,
    output logic [SRL_W-1:0]  srl_d,
    output logic              srl_ce,
    output logic [TAP_AW-1:0] srl_a,
    input  logic [SRL_W-1:0]  srl_y,
    output logic [TAP_AW-1:0] coef_a,
    input  logic [CW-1:0]     coef
);

`ifdef FIR_PIPE_EN
    localparam int MAC_LAST = TAPS;
`else
    localparam int MAC_LAST = TAPS - 1;
`endif
    localparam logic [KW-1:0] K_LAST = KW'(MAC_LAST);
    localparam logic [KW-1:0] K_TAPS = KW'(TAPS);

    state_t                 state;
    state_t                 stateNext;
    logic [KW-1:0]          k;
    logic                   tapValid;
    logic                   accept;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] doutQ;
    logic                   ovrQ;

    // In the pipelined build the last MAC cycle only drains the product register
    assign tapValid = (state == MAC) && (k < K_TAPS);
    assign accept   = smp.din_stb && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        srl_ce    = 1'b0;
        srl_a     = '0;
        case (state)
            IDLE: begin
                if (smp.din_stb) begin
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                srl_ce    = 1'b1;
                stateNext = MAC;
            end
            MAC: begin
                if (tapValid) begin
                    srl_a = k[TAP_AW-1:0];
                end
                if (k == K_LAST) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = smp.din_stb ? SHIFT : IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign coef_a       = srl_a;
    assign smp.dout_stb = (state == DONE);
    assign smp.busy     = (state != IDLE);
    assign smp.dout     = doutQ;
    assign smp.ovr      = ovrQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
        end else if (state == MAC) begin
            k <= k + 1'b1;
        end else begin
            k <= '0;
        end
    end

    // Strobes arriving mid-computation are dropped but remembered in the sticky flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srl_d <= '0;
            doutQ <= '0;
            ovrQ  <= 1'b0;
        end else begin
            if (accept) begin
                srl_d <= smp.din;
            end
            if (smp.din_stb && ((state == SHIFT) || (state == MAC))) begin
                ovrQ <= 1'b1;
            end
            if (state == DONE) begin
                doutQ <= acc;
            end
        end
    end

    fir_mac #(
        .CW   (CW),
        .ACCW (ACCW)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .first (k == '0),
        .valid (tapValid),
        .srl_y (srl_y),
        .coef  (coef),
        .acc   (acc)
    );

endmodule

// File: tb/tb_fir_seq16x6.sv
// Directed bench for fir_seq16x6: 16-tap and 2-tap instances with behavioural delay lines and coefficient tables.
// Expected latencies follow FIR_PIPE_EN.
module tb_fir_seq16x6;

`ifdef FIR_PIPE_EN
    localparam int LAT16 = 19;
    localparam int LAT2  = 5;
`else
    localparam int LAT16 = 18;
    localparam int LAT2  = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    int   assertCount = 0;
    int   failCount   = 0;

    always #5 clk = ~clk;

    fir_seq16x6_if #(.ACCW(22)) if16 ();
    fir_seq16x6_if #(.ACCW(22)) if2 ();

    logic [5:0]  srl_d16, srl_y16, srl_d2, srl_y2;
    logic        srl_ce16, srl_ce2;
    logic [3:0]  srl_a16, coef_a16, srl_a2, coef_a2;
    logic [11:0] coef16, coef2;

    logic [5:0]  line16 [16] = '{default: '0};
    logic [5:0]  line2  [16] = '{default: '0};
    logic [11:0] coefTab16 [16];
    logic [11:0] coefTab2  [16];

    fir_seq16x6 #(.TAPS(16), .CW(12), .ACCW(22)) u16 (
        .clk    (clk),
        .rst    (rst),
        .smp    (if16),
        .srl_d  (srl_d16),
        .srl_ce (srl_ce16),
        .srl_a  (srl_a16),
        .srl_y  (srl_y16),
        .coef_a (coef_a16),
        .coef   (coef16)
    );

    fir_seq16x6 #(.TAPS(2), .CW(12), .ACCW(22)) u2 (
        .clk    (clk),
        .rst    (rst),
        .smp    (if2),
        .srl_d  (srl_d2),
        .srl_ce (srl_ce2),
        .srl_a  (srl_a2),
        .srl_y  (srl_y2),
        .coef_a (coef_a2),
        .coef   (coef2)
    );

    // Behavioural delay lines: no reset, so history survives rst
    always @(posedge clk) begin
        if (srl_ce16) begin
            for (int i = 15; i > 0; i--) line16[i] <= line16[i-1];
            line16[0] <= srl_d16;
        end
        if (srl_ce2) begin
            for (int i = 15; i > 0; i--) line2[i] <= line2[i-1];
            line2[0] <= srl_d2;
        end
    end

    assign srl_y16 = line16[srl_a16];
    assign srl_y2  = line2[srl_a2];
    assign coef16  = coefTab16[coef_a16];
    assign coef2   = coefTab2[coef_a2];

    task automatic checkOutput(input string tag, input logic signed [63:0] got,
                               input logic signed [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic waitStrobe16(input int start, output int lat);
        lat = -1;
        for (int i = start; i <= 60; i++) begin
            @(negedge clk);
            if16.din_stb = 1'b0;
            if (if16.dout_stb === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Sends one sample to the 16-tap instance and returns the held result and latency
    task automatic applyStimulus(input logic signed [5:0] d, output logic signed [63:0] res,
                                 output int lat);
        if16.din     = d;
        if16.din_stb = 1'b1;
        waitStrobe16(1, lat);
        @(negedge clk);
        res = if16.dout;
    endtask

    task automatic applyStimulus2(input logic signed [5:0] d, output logic signed [63:0] res,
                                  output int lat);
        if2.din     = d;
        if2.din_stb = 1'b1;
        lat         = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if2.din_stb = 1'b0;
            if (if2.dout_stb === 1'b1) begin
                lat = i;
                break;
            end
        end
        @(negedge clk);
        res = if2.dout;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic signed [63:0] res;
        int lat, ceFirst, ceCount, stbFirst, stbCount;

        rst          = 1'b1;
        if16.din     = '0;
        if16.din_stb = 1'b0;
        if2.din      = '0;
        if2.din_stb  = 1'b0;
        for (int i = 0; i < 16; i++) coefTab16[i] = 12'(i + 1);
        for (int i = 0; i < 16; i++) coefTab2[i] = '0;
        coefTab2[0] = 12'sd3;
        coefTab2[1] = -12'sd1;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", if16.busy, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_dout", if16.dout, 0);
        checkOutput("reset_dout_stb", if16.dout_stb, 0);
        checkOutput("reset_ovr", if16.ovr, 0);
        checkOutput("reset_srl_ce", srl_ce16, 0);
        checkOutput("reset_srl_a", srl_a16, 0);
        checkOutput("reset_coef_a", coef_a16, 0);
        checkOutput("reset_srl_d", srl_d16, 0);

        // Two-tap instance: 5*3 = 15, then 7*3 + 5*(-1) = 16
        applyStimulus2(6'sd5, res, lat);
        checkOutput("taps2_first", res, 15);
        checkOutput("taps2_latency", lat, LAT2);
        applyStimulus2(6'sd7, res, lat);
        checkOutput("taps2_second", res, 16);

        // Impulse response reproduces coef[k] = k+1
        for (int n = 0; n < 16; n++) begin
            applyStimulus((n == 0) ? 6'sd1 : 6'sd0, res, lat);
            checkOutput($sformatf("impulse_%0d", n), res, n + 1);
            checkOutput($sformatf("impulse_lat_%0d", n), lat, LAT16);
        end

        // Full-scale DC: most negative sample times largest coefficient on every tap
        for (int i = 0; i < 16; i++) coefTab16[i] = 12'sd2047;
        for (int n = 0; n < 16; n++) begin
            applyStimulus(-6'sd32, res, lat);
            if (n == 0) checkOutput("dc_first", res, -65504);
        end
        checkOutput("dc_full", res, -1048064);

        // Cycle-exact latency of a lone strobe
        if16.din     = -6'sd32;
        if16.din_stb = 1'b1;
        ceFirst  = -1; ceCount  = 0;
        stbFirst = -1; stbCount = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if16.din_stb = 1'b0;
            if (srl_ce16 === 1'b1) begin
                ceCount++;
                if (ceFirst < 0) ceFirst = i;
            end
            if (if16.dout_stb === 1'b1) begin
                stbCount++;
                if (stbFirst < 0) stbFirst = i;
            end
            if (i == 7) begin
                checkOutput("mac_srl_a_k5", srl_a16, 5);
                checkOutput("mac_coef_a_k5", coef_a16, 5);
                checkOutput("mac_busy", if16.busy, 1);
            end
        end
        checkOutput("lat_ce_cycle", ceFirst, 1);
        checkOutput("lat_ce_count", ceCount, 1);
        checkOutput("lat_stb_cycle", stbFirst, LAT16);
        checkOutput("lat_stb_count", stbCount, 1);
        checkOutput("lat_dout", if16.dout, -1048064);
        checkOutput("lat_idle", if16.busy, 0);

        // Back-to-back: strobe during DONE is accepted
        for (int i = 0; i < 16; i++) coefTab16[i] = 12'sd1;
        if16.din     = 6'sd3;
        if16.din_stb = 1'b1;
        waitStrobe16(1, lat);
        checkOutput("b2b_first_lat", lat, LAT16);
        if16.din     = 6'sd5;
        if16.din_stb = 1'b1;
        @(negedge clk);
        if16.din_stb = 1'b0;
        checkOutput("b2b_srl_ce", srl_ce16, 1);
        checkOutput("b2b_first_dout", if16.dout, -477);
        waitStrobe16(2, lat);
        checkOutput("b2b_second_lat", lat, LAT16);
        @(negedge clk);
        checkOutput("b2b_second_dout", if16.dout, -440);
        checkOutput("b2b_no_ovr", if16.ovr, 0);

        // Overrun: second strobe lands in MAC and must be ignored
        if16.din     = 6'sd7;
        if16.din_stb = 1'b1;
        ceCount  = 0;
        stbCount = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if16.din_stb = 1'b0;
            if (srl_ce16 === 1'b1) ceCount++;
            if (if16.dout_stb === 1'b1) stbCount++;
            if (i == 5) begin
                if16.din     = 6'sd9;
                if16.din_stb = 1'b1;
            end
        end
        checkOutput("ovr_set", if16.ovr, 1);
        checkOutput("ovr_ce_count", ceCount, 1);
        checkOutput("ovr_stb_count", stbCount, 1);
        checkOutput("ovr_dout", if16.dout, -401);
        applyStimulus(6'sd1, res, lat);
        checkOutput("ovr_next_dout", res, -368);
        checkOutput("ovr_sticky", if16.ovr, 1);

        // Reset in the middle of MAC
        if16.din     = 6'sd2;
        if16.din_stb = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if16.din_stb = 1'b0;
        end
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_busy", if16.busy, 0);
        checkOutput("rst_mid_dout", if16.dout, 0);
        checkOutput("rst_mid_ovr", if16.ovr, 0);
        checkOutput("rst_mid_srl_a", srl_a16, 0);
        @(negedge clk);
        rst      = 1'b0;
        stbCount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if16.dout_stb === 1'b1) stbCount++;
        end
        checkOutput("rst_mid_no_stb", stbCount, 0);
        applyStimulus(6'sd4, res, lat);
        checkOutput("rst_history_dout", res, -298);
        checkOutput("rst_history_lat", lat, LAT16);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
